// File: rtl/common_dffram_fifo_ctrl.sv
// FIFO controller sequencing an external DFF RAM (port A write, port B async read).
// Holds only the pointers and occupancy count; payload lives entirely in the RAM.
module common_dffram_fifo_ctrl #(
    parameter int DATA_WIDTH        = 8,
    parameter int FIFO_DEPTH        = 4,
    parameter int ALMOST_FULL_LEVEL = FIFO_DEPTH - 1,
    localparam int PTR_WIDTH        = $clog2(FIFO_DEPTH),
    localparam int CNT_WIDTH        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [PTR_WIDTH-1:0]  ram_addra,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic [PTR_WIDTH-1:0]  ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_doutb
);

    localparam logic [PTR_WIDTH-1:0] LP_LAST_PTR = PTR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] LP_DEPTH    = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] LP_AF_LEVEL = CNT_WIDTH'(ALMOST_FULL_LEVEL);

    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [PTR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_push_fire;
    logic                 w_pop_fire;

    // Explicit wrap keeps non-power-of-two depths legal.
    function automatic logic [PTR_WIDTH-1:0] f_next_ptr(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == LP_LAST_PTR) ? '0 : ptr + PTR_WIDTH'(1);
    endfunction

    assign full        = (r_cnt == LP_DEPTH);
    assign empty       = (r_cnt == '0);
    assign almost_full = (r_cnt >= LP_AF_LEVEL);
    assign count       = r_cnt;
    assign s_ready     = ~full;
    assign m_valid     = ~empty;
    assign m_data      = ram_doutb;

    assign w_push_fire = s_valid & s_ready & ~reset & ~flush;
    assign w_pop_fire  = m_valid & m_ready & ~reset & ~flush;

    assign ram_addra = r_wr_ptr;
    assign ram_ena   = w_push_fire;
    assign ram_wea   = w_push_fire;
    assign ram_dina  = s_data;
    assign ram_addrb = r_rd_ptr;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push_fire) r_wr_ptr <= f_next_ptr(r_wr_ptr);
            if (w_pop_fire)  r_rd_ptr <= f_next_ptr(r_rd_ptr);
            case ({w_push_fire, w_pop_fire})
                2'b10:   r_cnt <= r_cnt + CNT_WIDTH'(1);
                2'b01:   r_cnt <= r_cnt - CNT_WIDTH'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_common_dffram_fifo_ctrl.sv
// Bench for the DFF-RAM FIFO controller: depth-4 and depth-3 instances share stimulus,
// each backed by a RAM model and checked against a queue-based FIFO reference.
module tb_common_dffram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset, flush, s_valid, m_ready;
    logic [7:0] s_data;

    logic       s_ready4, m_valid4, full4, empty4, af4, ena4, wea4;
    logic [7:0] m_data4, dina4, doutb4;
    logic [2:0] count4;
    logic [1:0] addra4, addrb4;

    logic       s_ready3, m_valid3, full3, empty3, af3, ena3, wea3;
    logic [7:0] m_data3, dina3, doutb3;
    logic [1:0] count3;
    logic [1:0] addra3, addrb3;

    logic [7:0] ram4 [4];
    logic [7:0] ram3 [3];

    int         n_chk  = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;

    logic [7:0] q4[$];
    logic [7:0] q3[$];
    int         widx [2];
    int         ridx [2];

    always #5 clk = ~clk;

    common_dffram_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready4), .s_data(s_data),
        .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
        .count(count4), .full(full4), .empty(empty4), .almost_full(af4),
        .ram_addra(addra4), .ram_ena(ena4), .ram_wea(wea4), .ram_dina(dina4),
        .ram_addrb(addrb4), .ram_doutb(doutb4)
    );

    common_dffram_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(3)) u_dut3 (
        .clk(clk), .reset(reset), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready3), .s_data(s_data),
        .m_valid(m_valid3), .m_ready(m_ready), .m_data(m_data3),
        .count(count3), .full(full3), .empty(empty3), .almost_full(af3),
        .ram_addra(addra3), .ram_ena(ena3), .ram_wea(wea3), .ram_dina(dina3),
        .ram_addrb(addrb3), .ram_doutb(doutb3)
    );

    always @(posedge clk) begin
        if (ena4 && wea4) ram4[addra4] <= dina4;
        if (ena3 && wea3 && addra3 < 2'd3) ram3[addra3] <= dina3;
    end
    assign doutb4 = ram4[addrb4];
    assign doutb3 = (addrb3 < 2'd3) ? ram3[addrb3] : 8'h00;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    task automatic check_inst(input int k, input int D, input int cnt, input int emp,
                              input int ful, input int af, input int srdy, input int mvld,
                              input int mdat, input int ena, input int wea, input int dina,
                              input int adra, input int adrb);
        int    sz, head, af_lvl;
        bit    push_exp, pop_exp;
        string p;
        p      = (k == 0) ? "d4" : "d3";
        af_lvl = D - 1;
        sz     = (k == 0) ? q4.size() : q3.size();
        head   = 0;
        if (sz > 0) head = (k == 0) ? int'(q4[0]) : int'(q3[0]);

        chk({p, "_count"}, cnt, sz);
        chk({p, "_empty"}, emp, int'(sz == 0));
        chk({p, "_full"}, ful, int'(sz == D));
        chk({p, "_almost_full"}, af, int'(sz >= af_lvl));
        chk({p, "_s_ready"}, srdy, int'(sz < D));
        chk({p, "_m_valid"}, mvld, int'(sz > 0));
        if (sz > 0) chk({p, "_m_data"}, mdat, head);
        chk({p, "_ram_addra"}, adra, widx[k]);
        chk({p, "_ram_addrb"}, adrb, ridx[k]);
        chk({p, "_wea_when_full"}, int'(wea != 0 && ful != 0), 0);
        chk({p, "_ptr_cnt_inv"}, (adra - adrb + D) % D, sz % D);

        push_exp = s_valid && (sz < D) && !reset && !flush;
        pop_exp  = m_ready && (sz > 0) && !reset && !flush;
        chk({p, "_ram_wea"}, wea, int'(push_exp));
        chk({p, "_ram_ena"}, ena, int'(push_exp));
        if (push_exp) chk({p, "_ram_dina"}, dina, int'(s_data));

        if (reset || flush) begin
            if (k == 0) q4.delete(); else q3.delete();
            widx[k] = 0;
            ridx[k] = 0;
        end else begin
            if (pop_exp) begin
                if (k == 0) void'(q4.pop_front()); else void'(q3.pop_front());
                ridx[k] = (ridx[k] + 1) % D;
            end
            if (push_exp) begin
                if (k == 0) q4.push_back(s_data); else q3.push_back(s_data);
                widx[k] = (widx[k] + 1) % D;
            end
        end
    endtask

    // Monitor: outputs are stable mid-cycle; compare, then advance the model for the next edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check_inst(0, 4, int'(count4), int'(empty4), int'(full4), int'(af4), int'(s_ready4),
                       int'(m_valid4), int'(m_data4), int'(ena4), int'(wea4), int'(dina4),
                       int'(addra4), int'(addrb4));
            check_inst(1, 3, int'(count3), int'(empty3), int'(full3), int'(af3), int'(s_ready3),
                       int'(m_valid3), int'(m_data3), int'(ena3), int'(wea3), int'(dina3),
                       int'(addra3), int'(addrb3));
        end
    end

    task automatic drive(input bit sv, input logic [7:0] d, input bit mr, input bit fl);
        s_valid = sv;
        s_data  = d;
        m_ready = mr;
        flush   = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        widx[0] = 0; widx[1] = 0; ridx[0] = 0; ridx[1] = 0;
        reset = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 8'h00;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        drive(1'b1, 8'hEE, 1'b1, 1'b0);
        reset = 1'b0;

        // Fill with m_ready low; fifth push must be ignored
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        drive(1'b1, 8'h44, 1'b0, 1'b0);
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Drain
        for (int i = 0; i < 6; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Push/pop pairs exercising wrap
        for (int i = 0; i < 7; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous push/pop at count 2
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        drive(1'b1, 8'h02, 1'b0, 1'b0);
        drive(1'b1, 8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush at count 3 with push and pop requested
        drive(1'b1, 8'h61, 1'b0, 1'b0);
        drive(1'b1, 8'h62, 1'b0, 1'b0);
        drive(1'b1, 8'h63, 1'b0, 1'b0);
        drive(1'b1, 8'h64, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Push while full, with a pop in the same cycle
        for (int i = 0; i < 4; i++) drive(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        drive(1'b1, 8'h7F, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Randomized traffic, including occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            drive(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 79) == 0));
        end
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
